// File: rtl/fc_neuron_mac.sv
// Two-stage multiply-accumulate for one fully-connected neuron: sum(x_k*w_k) + bias, one result per vector.
// Define FC_NEURON_MAC_SAT_EN to clamp each accumulation to the signed OUT_DATA_WIDTH range instead of wrapping.
module fc_neuron_mac #(
  parameter int IN_DATA_WIDTH  = 8,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_last,
  input  logic [IN_DATA_WIDTH-1:0]  i_data,
  input  logic [IN_DATA_WIDTH-1:0]  i_weight,
  input  logic [OUT_DATA_WIDTH-1:0] i_bias,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [OUT_DATA_WIDTH-1:0] o_result,
  output logic [CNT_WIDTH-1:0]      o_beats
);

  localparam int PW = 2 * IN_DATA_WIDTH;

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic                       accept;
  logic                       first_q;
  logic signed [PW-1:0]       p_q;
  logic                       p_valid_q, p_first_q, p_last_q;
  logic [OUT_DATA_WIDTH-1:0]  bias_q, acc_q, acc_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       valid_q;
  logic [OUT_DATA_WIDTH-1:0]  result_q;
  logic [CNT_WIDTH-1:0]       beats_q;
  logic [OUT_DATA_WIDTH-1:0]  base, addend, sum_raw;

  assign accept   = i_valid && o_ready;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_beats  = beats_q;

  // Stage 2 arithmetic: restart from the latched bias on the first product of a vector.
  always_comb begin
    base    = p_first_q ? bias_q : acc_q;
    addend  = {{(OUT_DATA_WIDTH-PW){p_q[PW-1]}}, p_q};
    sum_raw = base + addend;
`ifdef FC_NEURON_MAC_SAT_EN
    if ((base[OUT_DATA_WIDTH-1] == addend[OUT_DATA_WIDTH-1]) &&
        (sum_raw[OUT_DATA_WIDTH-1] != base[OUT_DATA_WIDTH-1])) begin
      acc_d = base[OUT_DATA_WIDTH-1] ? {1'b1, {(OUT_DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_DATA_WIDTH-1){1'b1}}};
    end else begin
      acc_d = sum_raw;
    end
`else
    acc_d = sum_raw;
`endif
    cnt_d = p_first_q ? {{(CNT_WIDTH-1){1'b0}}, 1'b1}
                      : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    case (state_q)
      S_ACC: begin
        o_ready = 1'b1;
        if (accept && i_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (p_valid_q && p_last_q) state_d = S_OUT;
      end
      S_OUT: begin
        if (valid_q && i_ready) state_d = S_ACC;
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_ACC;
      first_q   <= 1'b1;
      p_q       <= '0;
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      bias_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      beats_q   <= '0;
    end else begin
      state_q   <= state_d;
      p_valid_q <= accept;
      if (accept) begin
        p_q       <= $signed(i_data) * $signed(i_weight);
        p_first_q <= first_q;
        p_last_q  <= i_last;
        first_q   <= i_last;
        if (first_q) bias_q <= i_bias;
      end
      if (p_valid_q) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
      // The first S_OUT edge publishes the settled sum; results then hold until the handshake.
      if (state_q == S_OUT) begin
        if (!valid_q) begin
          valid_q  <= 1'b1;
          result_q <= acc_q;
          beats_q  <= cnt_q;
        end else if (i_ready) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_neuron_mac.sv
// Directed bench for fc_neuron_mac with a transaction-level reference model checked every cycle.
module tb_fc_neuron_mac;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_valid = 1'b0;
  logic               i_last = 1'b0;
  logic signed [7:0]  i_data = '0;
  logic signed [7:0]  i_weight = '0;
  logic [31:0]        i_bias = '0;
  logic               i_ready = 1'b1;
  logic               o_ready, o_valid;
  logic [31:0]        o_result;
  logic [15:0]        o_beats;

  int checks = 0;
  int errors = 0;

  fc_neuron_mac dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_last(i_last), .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_beats(o_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: vector-level sum with a fixed 2-cycle result delay.
  logic        m_busy, m_valid, m_first;
  int          m_wait;
  logic [31:0] m_acc, m_result;
  logic [15:0] m_n, m_beats;

  function automatic logic [31:0] madd(input logic [31:0] a, input int p);
    longint s;
    s = longint'($signed(a)) + longint'(p);
`ifdef FC_NEURON_MAC_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_first = 1; m_wait = 0;
      m_acc = 0; m_result = 0; m_n = 0; m_beats = 0;
    end else if (m_valid && i_ready) begin
      m_valid = 0;
      m_busy  = 0;
    end else if (!m_busy && i_valid) begin
      if (m_first) begin
        m_acc = i_bias;
        m_n   = 0;
      end
      m_acc   = madd(m_acc, int'(i_data) * int'(i_weight));
      m_n     = m_n + 16'd1;
      m_first = i_last;
      if (i_last) begin
        m_busy = 1;
        m_wait = 2;
      end
    end else if (m_busy && !m_valid) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid  = 1;
        m_result = m_acc;
        m_beats  = m_n;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_ready",  {31'd0, o_ready}, {31'd0, !m_busy});
      chk("cyc_valid",  {31'd0, o_valid}, {31'd0, m_valid});
      chk("cyc_result", o_result, m_result);
      chk("cyc_beats",  {16'd0, o_beats}, {16'd0, m_beats});
    end
  end

  task automatic beat(input logic signed [7:0] d, input logic signed [7:0] w,
                      input logic [31:0] b, input logic last);
    i_valid = 1; i_data = d; i_weight = w; i_bias = b; i_last = last;
    @(negedge clk);
    i_valid = 0; i_last = 0;
  endtask

  // Called right after the last beat; measures negedges until o_valid.
  task automatic wait_result(input string name, input logic [31:0] exp_res,
                             input logic [15:0] exp_beats, input logic consume);
    int lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 32'd2);
    chk({name, "_result"}, o_result, exp_res);
    chk({name, "_beats"}, {16'd0, o_beats}, {16'd0, exp_beats});
    if (consume) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready",  {31'd0, o_ready}, 32'd1);
    chk("rst_valid",  {31'd0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_beats",  {16'd0, o_beats}, 32'd0);
    rst = 0;
    @(negedge clk);

    beat(3, 4, 32'd10, 0);
    beat(-2, 5, 32'd10, 0);
    beat(7, -1, 32'd10, 1);
    wait_result("basic", 32'd5, 16'd3, 1);

    beat(2, 3, -32'sd100, 1);
    wait_result("single", 32'hFFFFFFA2, 16'd1, 1);

    i_ready = 0;
    beat(1, 1, 32'd7, 1);
    wait_result("bp_first", 32'd8, 16'd1, 0);
    i_valid = 1; i_data = 5; i_weight = 5; i_bias = 32'd99; i_last = 1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid",  {31'd0, o_valid}, 32'd1);
      chk("bp_ready",  {31'd0, o_ready}, 32'd0);
      chk("bp_result", o_result, 32'd8);
      @(negedge clk);
    end
    i_ready = 1; i_bias = 32'd20;
    @(negedge clk);
    @(negedge clk);
    i_valid = 0; i_last = 0;
    wait_result("bp_next", 32'd45, 16'd1, 1);

    beat(1, 1, 32'd0, 0);
    repeat (2) @(negedge clk);
    beat(1, 1, 32'd0, 1);
    wait_result("gap_v1", 32'd2, 16'd2, 1);
    beat(-1, -1, 32'd5, 1);
    wait_result("gap_v2", 32'd6, 16'd1, 1);

    beat(127, 127, 32'h7FFFFF00, 1);
`ifdef FC_NEURON_MAC_SAT_EN
    wait_result("ovf", 32'h7FFFFFFF, 16'd1, 1);
`else
    wait_result("ovf", 32'h80003E01, 16'd1, 1);
`endif

    beat(10, 10, 32'd3, 0);
    beat(10, 10, 32'd3, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_result", o_result, 32'd0);
    chk("mid_rst_beats",  {16'd0, o_beats}, 32'd0);
    chk("mid_rst_valid",  {31'd0, o_valid}, 32'd0);
    chk("mid_rst_ready",  {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    beat(2, 2, 32'd1, 1);
    wait_result("after_rst", 32'd5, 16'd1, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
